// File: rtl/tdma_tx_scheduler_if.sv
// Signal bundle between the PIO/network side and the TDMA transmit scheduler.
// The scheduler uses the slave modport.
interface tdma_tx_scheduler_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      send_data;
    logic             frame_sync;
    logic             overflow_clr;
    logic [31:0]      tdm_data;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic             busy;

    modport master (
        output send_data,
        output frame_sync,
        output overflow_clr,
        input  tdm_data,
        input  fifo_count,
        input  overflow,
        input  busy
    );

    modport slave (
        input  send_data,
        input  frame_sync,
        input  overflow_clr,
        output tdm_data,
        output fifo_count,
        output overflow,
        output busy
    );
endinterface

// File: rtl/tdma_tx_scheduler.sv
// TDMA transmit scheduler: queues toggle-flagged PIO payloads and sends one
// word per frame during this node's slot.
module tdma_tx_scheduler #(
    parameter int NODE_ID     = 0,
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    tdma_tx_scheduler_if.slave bus
);
    localparam int CYC_W  = $clog2(SLOT_CYCLES);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] NODE_SLOT = SLOT_W'(NODE_ID);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t            r_state;
    logic [31:0]       r_tdm;
    logic              r_busy;
    logic              r_tog_q;
    logic              r_overflow;
    logic [CYC_W-1:0]  r_cyc_cnt;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [30:0]       r_mem [FIFO_DEPTH];

    logic [CYC_W-1:0]  w_cyc_next;
    logic [SLOT_W-1:0] w_slot_next;
    logic              w_entry;
    logic              w_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Slot timer; NUM_SLOTS is a power of two so the slot counter wraps by itself.
    always_comb begin
        w_cyc_next  = r_cyc_cnt + CYC_W'(1);
        w_slot_next = r_slot_cnt;
        if (bus.frame_sync) begin
            w_cyc_next  = '0;
            w_slot_next = '0;
        end else if (r_cyc_cnt == CYC_LAST) begin
            w_cyc_next  = '0;
            w_slot_next = r_slot_cnt + SLOT_W'(1);
        end
    end

    assign w_entry = (w_slot_next == NODE_SLOT) && (w_cyc_next == '0);
    assign w_req   = bus.send_data[31] ^ r_tog_q;
    assign w_pop   = w_entry && (r_count != '0);
    // A pop on the same edge frees the slot a full FIFO would otherwise lack.
    assign w_push  = w_req && ((r_count < CNT_FULL) || w_pop);
    assign w_drop  = w_req && !w_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc_cnt  <= '0;
            r_slot_cnt <= '0;
            r_tog_q    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_cyc_cnt  <= w_cyc_next;
            r_slot_cnt <= w_slot_next;
            r_tog_q    <= bus.send_data[31];
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.send_data[30:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot entry always wins, which lets NODE_ID=0 reload on a sync that aborts a send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tdm   <= '0;
            r_busy  <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_SEND;
            r_tdm   <= {1'b1, r_mem[r_rd_ptr]};
            r_busy  <= 1'b1;
        end else if ((r_state == S_SEND) && (bus.frame_sync || (r_cyc_cnt == CYC_LAST))) begin
            r_state <= S_IDLE;
            r_tdm   <= '0;
            r_busy  <= 1'b0;
        end
    end

    assign bus.tdm_data   = r_tdm;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_tdma_tx_scheduler.sv
// Bench for tdma_tx_scheduler: vector table, hand-written corner sequences and
// a randomized run against a slot-time/queue reference model.
module tb_tdma_tx_scheduler;
    localparam int NID   = 2;
    localparam int NS    = 4;
    localparam int SC    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = NS * SC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tdma_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

    tdma_tx_scheduler #(
        .NODE_ID(NID), .NUM_SLOTS(NS), .SLOT_CYCLES(SC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sd;
        logic        fs;
        logic        oc;
        int          n;
        logic [31:0] tdm;
        int          cnt;
        logic        ovf;
        logic        busy;
    } vec_t;

    vec_t vecs[18];

    // Reference model: time within the frame plus a plain queue.
    int          m_t;
    logic [30:0] m_q[$];
    logic        m_tog;
    logic        m_ovf;
    logic        m_active;
    logic [30:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] e_tdm, input int e_cnt,
                           input logic e_ovf, input logic e_busy);
        chk({name, ".tdm_data"}, bus.tdm_data, e_tdm);
        chk({name, ".fifo_count"}, 32'(bus.fifo_count), 32'(e_cnt));
        chk({name, ".overflow"}, 32'(bus.overflow), 32'(e_ovf));
        chk({name, ".busy"}, 32'(bus.busy), 32'(e_busy));
    endtask

    // Drive inputs, let n edges pass, then check just after the last edge.
    task automatic apply(input string name, input logic [31:0] sd, input logic fs, input logic oc,
                         input int n, input logic [31:0] e_tdm, input int e_cnt,
                         input logic e_ovf, input logic e_busy);
        bus.send_data    = sd;
        bus.frame_sync   = fs;
        bus.overflow_clr = oc;
        repeat (n) @(posedge clk);
        #1;
        $display("%s: tdm=%h cnt=%0d ovf=%0b busy=%0b", name, bus.tdm_data, bus.fifo_count,
                 bus.overflow, bus.busy);
        chk_all(name, e_tdm, e_cnt, e_ovf, e_busy);
    endtask

    task automatic do_reset(input string name);
        bus.send_data    = '0;
        bus.frame_sync   = 1'b0;
        bus.overflow_clr = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_t = 0;
        m_q.delete();
        m_tog = 1'b0;
        m_ovf = 1'b0;
        m_active = 1'b0;
        m_word = '0;
        chk_all(name, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic model_step(input logic [31:0] sd, input logic fs, input logic oc);
        int nt;
        bit dropped;
        dropped = 0;
        nt = fs ? 0 : (m_t + 1) % FRAME;
        if ((nt == NID * SC) && (m_q.size() > 0)) begin
            m_word = m_q.pop_front();
            m_active = 1'b1;
        end else if (fs || ((nt / SC) != NID)) begin
            m_active = 1'b0;
        end
        if (sd[31] != m_tog) begin
            if (m_q.size() < DEPTH) m_q.push_back(sd[30:0]);
            else begin
                m_ovf = 1'b1;
                dropped = 1;
            end
            m_tog = sd[31];
        end
        if (oc && !dropped) m_ovf = 1'b0;
        m_t = nt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sd;
        logic        fs;
        logic        oc;

        vecs[0]  = '{32'h00000000, 1'b0, 1'b0, 1,  32'h00000000, 0, 1'b0, 1'b0};
        vecs[1]  = '{32'h92345678, 1'b0, 1'b0, 1,  32'h00000000, 1, 1'b0, 1'b0};
        vecs[2]  = '{32'h92345678, 1'b0, 1'b0, 5,  32'h00000000, 1, 1'b0, 1'b0};
        vecs[3]  = '{32'h92345678, 1'b0, 1'b0, 1,  32'h92345678, 0, 1'b0, 1'b1};
        vecs[4]  = '{32'h92345678, 1'b0, 1'b0, 3,  32'h92345678, 0, 1'b0, 1'b1};
        vecs[5]  = '{32'h92345678, 1'b0, 1'b0, 1,  32'h00000000, 0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000001, 1'b0, 1'b0, 1,  32'h00000000, 1, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000002, 1'b0, 1'b0, 1,  32'h00000000, 2, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000003, 1'b0, 1'b0, 1,  32'h00000000, 3, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000004, 1'b0, 1'b0, 1,  32'h00000000, 4, 1'b0, 1'b0};
        vecs[10] = '{32'h00000005, 1'b0, 1'b0, 1,  32'h00000000, 4, 1'b1, 1'b0};
        vecs[11] = '{32'h00000005, 1'b0, 1'b0, 6,  32'h00000000, 4, 1'b1, 1'b0};
        vecs[12] = '{32'h00000005, 1'b0, 1'b0, 1,  32'h80000001, 3, 1'b1, 1'b1};
        vecs[13] = '{32'h00000005, 1'b0, 1'b1, 1,  32'h80000001, 3, 1'b0, 1'b1};
        vecs[14] = '{32'h00000005, 1'b0, 1'b0, 3,  32'h00000000, 3, 1'b0, 1'b0};
        vecs[15] = '{32'h00000005, 1'b0, 1'b0, 12, 32'h80000002, 2, 1'b0, 1'b1};
        vecs[16] = '{32'h00000005, 1'b0, 1'b0, 4,  32'h00000000, 2, 1'b0, 1'b0};
        vecs[17] = '{32'h00000005, 1'b0, 1'b0, 12, 32'h80000003, 1, 1'b0, 1'b1};

        bus.send_data    = '0;
        bus.frame_sync   = 1'b0;
        bus.overflow_clr = 1'b0;

        do_reset("reset0");
        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].sd, vecs[i].fs, vecs[i].oc, vecs[i].n,
                  vecs[i].tdm, vecs[i].cnt, vecs[i].ovf, vecs[i].busy);
        end

        // Fifth write lands on the slot entry edge of a full FIFO.
        do_reset("resetA");
        apply("fillA1", 32'h800000A1, 1'b0, 1'b0, 1, 32'h0, 1, 1'b0, 1'b0);
        apply("fillA2", 32'h000000A2, 1'b0, 1'b0, 1, 32'h0, 2, 1'b0, 1'b0);
        apply("fillA3", 32'h800000A3, 1'b0, 1'b0, 1, 32'h0, 3, 1'b0, 1'b0);
        apply("fillA4", 32'h000000A4, 1'b0, 1'b0, 1, 32'h0, 4, 1'b0, 1'b0);
        apply("holdA",  32'h000000A4, 1'b0, 1'b0, 3, 32'h0, 4, 1'b0, 1'b0);
        apply("entryA", 32'h800000A5, 1'b0, 1'b0, 1, 32'h800000A1, 4, 1'b0, 1'b1);
        apply("sendA2", 32'h800000A5, 1'b0, 1'b0, 16, 32'h800000A2, 3, 1'b0, 1'b1);
        apply("sendA3", 32'h800000A5, 1'b0, 1'b0, 16, 32'h800000A3, 2, 1'b0, 1'b1);
        apply("sendA4", 32'h800000A5, 1'b0, 1'b0, 16, 32'h800000A4, 1, 1'b0, 1'b1);
        apply("sendA5", 32'h800000A5, 1'b0, 1'b0, 16, 32'h800000A5, 0, 1'b0, 1'b1);

        // frame_sync on the second SEND cycle aborts the word.
        do_reset("resetB");
        apply("pushB1", 32'h800000B1, 1'b0, 1'b0, 1, 32'h0, 1, 1'b0, 1'b0);
        apply("pushB2", 32'h000000B2, 1'b0, 1'b0, 1, 32'h0, 2, 1'b0, 1'b0);
        apply("sendB1", 32'h000000B2, 1'b0, 1'b0, 6, 32'h800000B1, 1, 1'b0, 1'b1);
        apply("send2B", 32'h000000B2, 1'b0, 1'b0, 1, 32'h800000B1, 1, 1'b0, 1'b1);
        apply("syncB",  32'h000000B2, 1'b1, 1'b0, 1, 32'h0, 1, 1'b0, 1'b0);
        apply("waitB",  32'h000000B2, 1'b0, 1'b0, 7, 32'h0, 1, 1'b0, 1'b0);
        apply("sendB2", 32'h000000B2, 1'b0, 1'b0, 1, 32'h800000B2, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a send with three words queued.
        do_reset("resetC");
        apply("pushC1", 32'h800000C1, 1'b0, 1'b0, 1, 32'h0, 1, 1'b0, 1'b0);
        apply("pushC2", 32'h000000C2, 1'b0, 1'b0, 1, 32'h0, 2, 1'b0, 1'b0);
        apply("pushC3", 32'h800000C3, 1'b0, 1'b0, 1, 32'h0, 3, 1'b0, 1'b0);
        apply("pushC4", 32'h000000C4, 1'b0, 1'b0, 1, 32'h0, 4, 1'b0, 1'b0);
        apply("sendC1", 32'h000000C4, 1'b0, 1'b0, 4, 32'h800000C1, 3, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        $display("midreset: tdm=%h cnt=%0d busy=%0b", bus.tdm_data, bus.fifo_count, bus.busy);
        chk_all("midreset", 32'h0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("quietC%0d", i), 32'h000000C4, 1'b0, 1'b0, 1, 32'h0, 0, 1'b0, 1'b0);
        end
        apply("pushD1", 32'h800000D1, 1'b0, 1'b0, 1, 32'h0, 1, 1'b0, 1'b0);

        // Randomized run against the reference model.
        do_reset("resetR");
        sd = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, (i < 400) ? 2 : 19) == 0) sd[31] = ~sd[31];
            sd[30:0] = 31'($urandom);
            fs = ($urandom_range(0, 49) == 0);
            oc = ($urandom_range(0, 19) == 0);
            bus.send_data    = sd;
            bus.frame_sync   = fs;
            bus.overflow_clr = oc;
            @(posedge clk);
            model_step(sd, fs, oc);
            #1;
            chk_all($sformatf("rand%0d", i), m_active ? {1'b1, m_word} : 32'h0,
                    m_q.size(), m_ovf, m_active);
        end
        $display("random run: %0d cycles, final count=%0d", 800, bus.fifo_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
